// File: rtl/wb_pkg.sv
// Shared write-back constants for the MEM/WB register and its load aligner.
//  - WDSEL_*: write-data select encodings seen at the write-back mux.
//  - F3_*   : load funct3 encodings used by the aligner.
package wb_pkg;

  localparam logic [1:0] WDSEL_ALU  = 2'd0;
  localparam logic [1:0] WDSEL_DRAM = 2'd1;
  localparam logic [1:0] WDSEL_PC4  = 2'd2;
  localparam logic [1:0] WDSEL_ILL  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_reg_load_align.sv
// load_align: combinational load-data alignment and extension.
// Ports:
//  word     in   XLEN  raw aligned DRAM word
//  off      in   2     byte offset within the word
//  funct3   in   3     load type
//  data     out  XLEN  selected byte/half/word, sign- or zero-extended
//  misalign out  1     access crosses its natural alignment (half odd, word non-zero)
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane pick from the byte offset
  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Extension and alignment-fault detection
  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = off[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = off[0];
      end
      F3_LW:   misalign = (off != 2'd0);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register of the RV32I core.
// Captures the MEM result bundle with load data aligned/extended ahead of the flops.
// Priority per edge: rst > flush > stall > capture. Flush clears valid/rf_we/misalign
// only; data fields keep their value.
// Ports: clk, rst (async, active-high), stall, flush, mem_* (MEM bundle in),
//  wb_* (registered WB bundle out), wb_misalign.
// Optional: define WB_INSTRET_EN to add the retire counter output instret.
module mem_wb_reg
  import wb_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 5
`ifdef WB_INSTRET_EN
  ,
  parameter int unsigned INSTRET_W = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_pc4,
  input  logic [XLEN-1:0]   mem_alu_c,
  input  logic [XLEN-1:0]   mem_dram_rd,
  input  logic [2:0]        mem_funct3,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_we,
  input  logic [1:0]        mem_wd_sel,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc4,
  output logic [XLEN-1:0]   wb_alu_c,
  output logic [XLEN-1:0]   wb_dram_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_rf_we,
  output logic [1:0]        wb_wd_sel,
  output logic              wb_misalign
`ifdef WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  logic [XLEN-1:0] align_data;
  logic            align_mis;
  logic            mis_c;
  logic            we_c;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word     (mem_dram_rd),
    .off      (mem_alu_c[1:0]),
    .funct3   (mem_funct3),
    .data     (align_data),
    .misalign (align_mis)
  );

  // Misalignment only matters when the load data is the write-back source
  assign mis_c = align_mis & (mem_wd_sel == WDSEL_DRAM);
  assign we_c  = mem_valid & mem_rf_we & (mem_rd != '0) & (mem_wd_sel != WDSEL_ILL) & ~mis_c;

  logic              valid_n, rf_we_n, mis_n;
  logic [XLEN-1:0]   pc4_n, alu_n, dram_n;
  logic [REG_AW-1:0] rd_n;
  logic [1:0]        sel_n;

  // Next-state: hold by default, flush clears control, otherwise capture
  always_comb begin
    valid_n = wb_valid;
    rf_we_n = wb_rf_we;
    mis_n   = wb_misalign;
    pc4_n   = wb_pc4;
    alu_n   = wb_alu_c;
    dram_n  = wb_dram_rd;
    rd_n    = wb_rd;
    sel_n   = wb_wd_sel;
    if (flush) begin
      valid_n = 1'b0;
      rf_we_n = 1'b0;
      mis_n   = 1'b0;
    end else if (!stall) begin
      valid_n = mem_valid;
      rf_we_n = we_c;
      mis_n   = mis_c;
      pc4_n   = mem_pc4;
      alu_n   = mem_alu_c;
      dram_n  = mis_c ? '0 : align_data;
      rd_n    = mem_rd;
      sel_n   = mem_wd_sel;
    end
  end

  // Pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_rf_we    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_pc4      <= '0;
      wb_alu_c    <= '0;
      wb_dram_rd  <= '0;
      wb_rd       <= '0;
      wb_wd_sel   <= WDSEL_ALU;
    end else begin
      wb_valid    <= valid_n;
      wb_rf_we    <= rf_we_n;
      wb_misalign <= mis_n;
      wb_pc4      <= pc4_n;
      wb_alu_c    <= alu_n;
      wb_dram_rd  <= dram_n;
      wb_rd       <= rd_n;
      wb_wd_sel   <= sel_n;
    end
  end

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  // Retire counter: counts every captured valid instruction, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (!flush && !stall && mem_valid) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed self-checking bench for mem_wb_reg.
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc4 = '0;
  logic [31:0] mem_alu_c = '0;
  logic [31:0] mem_dram_rd = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [4:0]  mem_rd = '0;
  logic        mem_rf_we = 1'b0;
  logic [1:0]  mem_wd_sel = '0;
  logic        wb_valid;
  logic [31:0] wb_pc4;
  logic [31:0] wb_alu_c;
  logic [31:0] wb_dram_rd;
  logic [4:0]  wb_rd;
  logic        wb_rf_we;
  logic [1:0]  wb_wd_sel;
  logic        wb_misalign;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_wb_reg dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_pc4     (mem_pc4),
    .mem_alu_c   (mem_alu_c),
    .mem_dram_rd (mem_dram_rd),
    .mem_funct3  (mem_funct3),
    .mem_rd      (mem_rd),
    .mem_rf_we   (mem_rf_we),
    .mem_wd_sel  (mem_wd_sel),
    .wb_valid    (wb_valid),
    .wb_pc4      (wb_pc4),
    .wb_alu_c    (wb_alu_c),
    .wb_dram_rd  (wb_dram_rd),
    .wb_rd       (wb_rd),
    .wb_rf_we    (wb_rf_we),
    .wb_wd_sel   (wb_wd_sel),
    .wb_misalign (wb_misalign)
`ifdef WB_INSTRET_EN
    ,
    .instret     (instret)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] alu,
                       input logic [31:0] dram, input logic [2:0] f3, input logic [4:0] rd,
                       input logic we, input logic [1:0] sel);
    mem_valid   = v;
    mem_pc4     = pc4;
    mem_alu_c   = alu;
    mem_dram_rd = dram;
    mem_funct3  = f3;
    mem_rd      = rd;
    mem_rf_we   = we;
    mem_wd_sel  = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, $urandom, $urandom, $urandom, 3'($urandom), 5'($urandom), 1'b1, 2'($urandom));
    tick();
    tick();
    vec_cnt++;
    if ({wb_valid, wb_pc4, wb_alu_c, wb_dram_rd, wb_rd, wb_rf_we, wb_wd_sel, wb_misalign} !== '0) begin
      err_cnt++;
      $display("FAIL reset_zero: got valid=%b pc4=%h alu=%h dram=%h rd=%h we=%b sel=%h mis=%b expected all 0",
               wb_valid, wb_pc4, wb_alu_c, wb_dram_rd, wb_rd, wb_rf_we, wb_wd_sel, wb_misalign);
    end
    drive(1'b1, 32'h0, 32'd5, 32'h0, 3'b010, 5'd3, 1'b1, 2'd0);
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (wb_alu_c !== 32'd5 || wb_rf_we !== 1'b1 || wb_rd !== 5'd3 || wb_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release: got alu=%h we=%b rd=%h valid=%b expected alu=5 we=1 rd=3 valid=1",
               wb_alu_c, wb_rf_we, wb_rd, wb_valid);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  off [4] = '{2'd0, 2'd3, 2'd2, 2'd0};
    logic [31:0] exp [4] = '{32'hFFFF_FFA1, 32'h0000_0080, 32'hFFFF_8077, 32'h0000_F0A1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0, {30'h0400_0000, off[i]}, 32'h8077_F0A1, f3[i], 5'd5, 1'b1, 2'd1);
      tick();
      vec_cnt++;
      if (wb_dram_rd !== exp[i] || wb_misalign !== 1'b0 || wb_rf_we !== 1'b1) begin
        err_cnt++;
        $display("FAIL load_extend[%0d]: got dram=%h mis=%b we=%b expected dram=%h mis=0 we=1",
                 i, wb_dram_rd, wb_misalign, wb_rf_we, exp[i]);
      end
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h0, 32'h0000_0102, 32'h8077_F0A1, 3'b010, 5'd6, 1'b1, 2'd1);
    tick();
    vec_cnt++;
    if (wb_misalign !== 1'b1 || wb_dram_rd !== 32'h0 || wb_rf_we !== 1'b0 || wb_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL misalign_lw: got mis=%b dram=%h we=%b valid=%b expected mis=1 dram=0 we=0 valid=1",
               wb_misalign, wb_dram_rd, wb_rf_we, wb_valid);
    end
    drive(1'b1, 32'h0, 32'h0000_0101, 32'h8077_F0A1, 3'b101, 5'd6, 1'b1, 2'd1);
    tick();
    vec_cnt++;
    if (wb_misalign !== 1'b1 || wb_dram_rd !== 32'h0 || wb_rf_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL misalign_lhu: got mis=%b dram=%h we=%b expected mis=1 dram=0 we=0",
               wb_misalign, wb_dram_rd, wb_rf_we);
    end
    // Misalignment is ignored when the load data is not the write-back source
    drive(1'b1, 32'h0, 32'h0000_0102, 32'h8077_F0A1, 3'b010, 5'd6, 1'b1, 2'd0);
    tick();
    vec_cnt++;
    if (wb_misalign !== 1'b0 || wb_dram_rd !== 32'h8077_F0A1 || wb_rf_we !== 1'b1) begin
      err_cnt++;
      $display("FAIL misalign_alu_sel: got mis=%b dram=%h we=%b expected mis=0 dram=8077f0a1 we=1",
               wb_misalign, wb_dram_rd, wb_rf_we);
    end
  endtask

  task automatic test_gating();
    drive(1'b1, 32'h0, 32'h10, 32'h0, 3'b010, 5'd0, 1'b1, 2'd0);
    tick();
    vec_cnt++;
    if (wb_rf_we !== 1'b0 || wb_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL gate_rd0: got we=%b valid=%b expected we=0 valid=1", wb_rf_we, wb_valid);
    end
    drive(1'b1, 32'h0, 32'h10, 32'h0, 3'b010, 5'd9, 1'b1, 2'd3);
    tick();
    vec_cnt++;
    if (wb_rf_we !== 1'b0 || wb_wd_sel !== 2'd3) begin
      err_cnt++;
      $display("FAIL gate_sel3: got we=%b sel=%h expected we=0 sel=3", wb_rf_we, wb_wd_sel);
    end
    drive(1'b1, 32'h104, 32'h10, 32'h0, 3'b010, 5'd9, 1'b1, 2'd2);
    tick();
    vec_cnt++;
    if (wb_pc4 !== 32'h104 || wb_rf_we !== 1'b1 || wb_wd_sel !== 2'd2 || wb_rd !== 5'd9) begin
      err_cnt++;
      $display("FAIL gate_pc4: got pc4=%h we=%b sel=%h rd=%h expected pc4=104 we=1 sel=2 rd=9",
               wb_pc4, wb_rf_we, wb_wd_sel, wb_rd);
    end
    drive(1'b0, 32'h104, 32'h10, 32'h0, 3'b010, 5'd9, 1'b1, 2'd0);
    tick();
    vec_cnt++;
    if (wb_rf_we !== 1'b0 || wb_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL gate_invalid: got we=%b valid=%b expected we=0 valid=0", wb_rf_we, wb_valid);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h200, 32'h0000_AAAA, 32'h0, 3'b010, 5'd7, 1'b1, 2'd0);
    tick();
    stall = 1'b1;
    drive(1'b1, 32'h300, 32'h0000_5555, 32'h0, 3'b010, 5'd12, 1'b0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (wb_alu_c !== 32'h0000_AAAA || wb_pc4 !== 32'h200 || wb_rd !== 5'd7 ||
          wb_rf_we !== 1'b1 || wb_valid !== 1'b1 || wb_wd_sel !== 2'd0) begin
        err_cnt++;
        $display("FAIL stall_hold[%0d]: got alu=%h pc4=%h rd=%h we=%b valid=%b sel=%h expected alu=aaaa pc4=200 rd=7 we=1 valid=1 sel=0",
                 i, wb_alu_c, wb_pc4, wb_rd, wb_rf_we, wb_valid, wb_wd_sel);
      end
    end
    flush = 1'b1;
    tick();
    vec_cnt++;
    if (wb_valid !== 1'b0 || wb_rf_we !== 1'b0 || wb_misalign !== 1'b0 || wb_alu_c !== 32'h0000_AAAA) begin
      err_cnt++;
      $display("FAIL stall_flush: got valid=%b we=%b mis=%b alu=%h expected valid=0 we=0 mis=0 alu=aaaa",
               wb_valid, wb_rf_we, wb_misalign, wb_alu_c);
    end
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'h400, 32'h0000_1234, 32'h0, 3'b010, 5'd8, 1'b1, 2'd0);
    tick();
    // Async reset in the middle of a stall, checked before the next edge
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (wb_valid !== 1'b0 || wb_alu_c !== 32'h0 || wb_rf_we !== 1'b0 || wb_rd !== 5'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got valid=%b alu=%h we=%b rd=%h expected all 0",
               wb_valid, wb_alu_c, wb_rf_we, wb_rd);
    end
    tick();
    rst   = 1'b0;
    stall = 1'b0;
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (instret !== 64'd0) begin
      err_cnt++;
      $display("FAIL instret_reset: got %h expected 0", instret);
    end
    drive(1'b1, 32'h0, 32'h0, 32'h0, 3'b010, 5'd1, 1'b1, 2'd0);
    tick();
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    mem_wd_sel = 2'd3;
    tick();
    mem_valid = 1'b0;
    vec_cnt++;
    if (instret !== 64'd4) begin
      err_cnt++;
      $display("FAIL instret_count: got %0d expected 4", instret);
    end
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    vec_cnt++;
    if (instret !== 64'd0) begin
      err_cnt++;
      $display("FAIL instret_wrap: got %h expected 0", instret);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_extend();
    test_misalign();
    test_gating();
    test_stall_flush();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
